// File: rtl/traffic_light_guard.sv
// Safety guard between the light controller and the LEDs. Qualifies lamp patterns, passes legal ones through,
// latches the first fault and flashes yellow until cleared. Optional timeout check: define GUARD_TIMEOUT_EN.
module traffic_light_guard #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int STABLE_CYC  = 4,
  parameter int MAX_PHASE_S = 8
) (
  input  logic       OG_clk,
  input  logic       reset,
  input  logic [2:0] LightA_in,
  input  logic [2:0] LightB_in,
  input  logic       clr,
  output logic [2:0] LightA_out,
  output logic [2:0] LightB_out,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HALF = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
  localparam int FW   = $clog2(HALF + 1);
  localparam int SW   = $clog2(STABLE_CYC + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] HALF_LAST = FW'(HALF - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [2:0]    YEL       = 3'b010;

  typedef enum logic {ST_PASS, ST_FAULT} state_t;

  logic [6:0]    sync1_q, sync2_q;
  logic [5:0]    hold_q, q_q, qprev_q;
  logic [SW-1:0] stab_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick, clr_s, q_chg;
  logic [5:0]    lights_s;

  state_t        state_q, state_d;
  logic [2:0]    code_q, code_d, det_code;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic          flash_off_q, flash_off_d;
  logic [2:0]    out_a_q, out_a_d, out_b_q, out_b_d;
  logic          illegal, conflict, seq_err, timeout;

  assign clr_s    = sync2_q[6];
  assign lights_s = sync2_q[5:0];
  assign tick     = (tick_cnt_q == TICK_LAST);
  assign q_chg    = (q_q != qprev_q);

  // A sample only becomes Q once the synchronised value has been seen STABLE_CYC times in a row.
  always_ff @(posedge OG_clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      hold_q     <= '0;
      stab_q     <= '0;
      q_q        <= '0;
      qprev_q    <= '0;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= {clr, LightA_in, LightB_in};
      sync2_q    <= sync1_q;
      qprev_q    <= q_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      if (lights_s != hold_q) begin
        hold_q <= lights_s;
        stab_q <= SW'(1);
      end else if (stab_q < STAB_LAST) begin
        stab_q <= stab_q + 1'b1;
      end else begin
        q_q <= hold_q;
      end
    end
  end

  function automatic logic road_ok(input logic [2:0] r);
    return r inside {3'b000, 3'b001, 3'b010, 3'b100};
  endfunction

  function automatic logic bad_step(input logic [2:0] p, input logic [2:0] n);
    return (p == 3'b001 && n == 3'b100) || (p == 3'b010 && n == 3'b001) ||
           (p == 3'b100 && n == 3'b010);
  endfunction

  assign illegal  = !road_ok(q_q[5:3]) || !road_ok(q_q[2:0]) ||
                    ((q_q[5:3] == 3'b000) != (q_q[2:0] == 3'b000));
  assign conflict = (q_q[5:3] inside {3'b001, 3'b010}) && (q_q[2:0] inside {3'b001, 3'b010});
  assign seq_err  = q_chg && (bad_step(qprev_q[5:3], q_q[5:3]) || bad_step(qprev_q[2:0], q_q[2:0]));

`ifdef GUARD_TIMEOUT_EN
  localparam int PW = $clog2(MAX_PHASE_S + 2);
  localparam logic [PW-1:0] PHASE_LIM = PW'(MAX_PHASE_S + 1);
  logic [PW-1:0] phase_q;

  // Counts ticks of the current pattern; the count left over from a pattern that just ended is ignored.
  always_ff @(posedge OG_clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
    end else if (q_chg || q_q == 6'd0) begin
      phase_q <= '0;
    end else if (tick && phase_q != PHASE_LIM) begin
      phase_q <= phase_q + 1'b1;
    end
  end

  assign timeout = (phase_q == PHASE_LIM) && !q_chg && (q_q != 6'd0);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    det_code = 3'd0;
    if (illegal)       det_code = 3'd1;
    else if (conflict) det_code = 3'd2;
    else if (seq_err)  det_code = 3'd3;
    else if (timeout)  det_code = 3'd4;
  end

  always_ff @(posedge OG_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_PASS;
      code_q      <= '0;
      flash_cnt_q <= '0;
      flash_off_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      flash_cnt_q <= flash_cnt_d;
      flash_off_q <= flash_off_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  // Fault entry shows yellow on the same edge, so an unsafe pattern never reaches the LEDs.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    flash_cnt_d = flash_cnt_q;
    flash_off_d = flash_off_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    case (state_q)
      ST_PASS: begin
        if (det_code != 3'd0) begin
          state_d     = ST_FAULT;
          code_d      = det_code;
          flash_cnt_d = '0;
          flash_off_d = 1'b0;
          out_a_d     = YEL;
          out_b_d     = YEL;
        end else begin
          out_a_d = q_q[5:3];
          out_b_d = q_q[2:0];
        end
      end
      ST_FAULT: begin
        if (clr_s && q_q == 6'd0) begin
          state_d     = ST_PASS;
          code_d      = '0;
          flash_cnt_d = '0;
          flash_off_d = 1'b0;
          out_a_d     = '0;
          out_b_d     = '0;
        end else begin
          if (flash_cnt_q == HALF_LAST) begin
            flash_cnt_d = '0;
            flash_off_d = ~flash_off_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 1'b1;
          end
          out_a_d = flash_off_d ? 3'b000 : YEL;
          out_b_d = flash_off_d ? 3'b000 : YEL;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  assign LightA_out = out_a_q;
  assign LightB_out = out_b_q;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_guard.sv
// Bench for traffic_light_guard: directed scenarios plus random lamp traffic checked every cycle
// against an edge-counting reference model.
module tb_traffic_light_guard;

  localparam int T    = 10;
  localparam int S    = 2;
  localparam int MAXP = 8;
  localparam int HALF = T / 2;
`ifdef GUARD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic [2:0] la = 3'b000, lb = 3'b000;
  logic [2:0] oa, ob, code;
  logic       flt;

  traffic_light_guard #(.TICK_DIV(T), .STABLE_CYC(S), .MAX_PHASE_S(MAXP)) dut (
    .OG_clk(clk), .reset(rst_n), .LightA_in(la), .LightB_in(lb), .clr(clr),
    .LightA_out(oa), .LightB_out(ob), .fault(flt), .fault_code(code)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist holds the raw {clr,A,B} input sampled at the last S+2 edges (oldest first).
  logic [6:0] hist[$];
  logic [5:0] m_q, m_qp;
  logic [2:0] m_oa, m_ob, m_code;
  logic       m_flt;
  int         m_edge, m_chg, m_fent;

  function automatic int color(input logic [2:0] r);
    case (r)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  // Legal order is green -> yellow -> red -> green; stepping one place backwards is a sequence fault.
  function automatic bit backward(input logic [2:0] p, input logic [2:0] n);
    return color(p) >= 0 && color(n) >= 0 && color(n) == (color(p) + 2) % 3;
  endfunction

  function automatic int fault_of(input logic [5:0] q, input logic [5:0] qp, input int n);
    logic [2:0] a, b, pa, pb;
    {a, b}   = q;
    {pa, pb} = qp;
    if ($countones(a) > 1 || $countones(b) > 1 || ((a == 3'd0) ^ (b == 3'd0))) return 1;
    if (a != 3'd0 && b != 3'd0 && !a[2] && !b[2]) return 2;
    if (q != qp && (backward(pa, a) || backward(pb, b))) return 3;
    // ticks occur at edges that are multiples of T; count those after the change was seen
    if (TO_EN && q != 6'd0 && q == qp && ((n - 1) / T - (m_chg + 1) / T) >= MAXP + 1) return 4;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back(7'd0);
      m_q = '0; m_qp = '0; m_oa = '0; m_ob = '0; m_code = '0; m_flt = 1'b0;
      m_edge = 0; m_chg = 0; m_fent = 0;
    end else begin
      logic [5:0] oq, oqp, nq;
      logic       stable;
      int         fc;
      m_edge++;
      hist.push_back({clr, la, lb});
      void'(hist.pop_front());
      oq  = m_q;
      oqp = m_qp;
      stable = 1'b1;
      for (int j = 1; j < S; j++) if (hist[j][5:0] != hist[0][5:0]) stable = 1'b0;
      nq = stable ? hist[0][5:0] : oq;
      if (!m_flt) begin
        fc = fault_of(oq, oqp, m_edge);
        if (fc != 0) begin
          m_flt = 1'b1; m_code = 3'(fc); m_fent = m_edge;
          {m_oa, m_ob} = 6'b010_010;
        end else begin
          {m_oa, m_ob} = oq;
        end
      end else if (hist[S-1][6] && oq == 6'd0) begin
        m_flt = 1'b0; m_code = '0; {m_oa, m_ob} = 6'd0;
      end else begin
        {m_oa, m_ob} = (((m_edge - m_fent) / HALF) % 2 == 0) ? 6'b010_010 : 6'd0;
      end
      m_qp = oq;
      m_q  = nq;
      if (nq != oq) m_chg = m_edge;
    end
  end

  bit cyc_en = 1'b0;
  always @(negedge clk) begin
    if (cyc_en) check_eq("cycle", 32'({oa, ob, flt, code}), 32'({m_oa, m_ob, m_flt, m_code}));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic c, input int cyc);
    @(negedge clk);
    la = a; lb = b; clr = c;
    repeat (cyc - 1) @(negedge clk);
  endtask

  task automatic wait_flt(input logic want, input int budget, input string tag);
    int i = 0;
    while (flt !== want && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, 32'(flt), 32'(want));
  endtask

  logic [5:0] norm [4] = '{6'b001_100, 6'b010_100, 6'b100_001, 6'b100_010};
  int         norm_ticks [4] = '{3, 1, 4, 1};

  initial begin
    int idx;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", 32'({oa, ob, flt, code}), 32'd0);
    rst_n  = 1'b1;
    cyc_en = 1'b1;
    repeat (2) @(negedge clk);

    // pass-through latency is 5 cycles
    la = 3'b001; lb = 3'b100;
    repeat (4) @(negedge clk);
    check_eq("latency_before", 32'({oa, ob}), 32'd0);
    @(negedge clk);
    check_eq("latency_after", 32'({oa, ob}), 32'(6'b001_100));

    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++)
        drive(norm[p][5:3], norm[p][2:0], 1'b0, norm_ticks[p] * T);
    check_eq("normal_no_fault", 32'(flt), 32'd0);

    // single-cycle glitch is filtered
    drive(3'b001, 3'b100, 1'b0, 20);
    drive(3'b111, 3'b100, 1'b0, 1);
    drive(3'b001, 3'b100, 1'b0, 12);
    check_eq("glitch_no_fault", 32'(flt), 32'd0);
    check_eq("glitch_out", 32'({oa, ob}), 32'(6'b001_100));

    // A green straight to red
    drive(3'b100, 3'b100, 1'b0, 10);
    check_eq("seq_fault", 32'(flt), 32'd1);
    check_eq("seq_code", 32'(code), 32'd3);

    // clear needs all-off inputs
    drive(3'b001, 3'b100, 1'b1, 12);
    check_eq("clr_ignored_flt", 32'(flt), 32'd1);
    check_eq("clr_ignored_code", 32'(code), 32'd3);
    drive(3'b000, 3'b000, 1'b1, 8);
    check_eq("clr_exit", 32'({oa, ob, flt, code}), 32'd0);
    drive(3'b001, 3'b100, 1'b0, 6);
    check_eq("pass_after_clr", 32'({oa, ob}), 32'(6'b001_100));

    // conflict and flash cadence
    @(negedge clk);
    la = 3'b001; lb = 3'b001;
    wait_flt(1'b1, 20, "conflict_fault");
    check_eq("conflict_code", 32'(code), 32'd2);
    check_eq("flash_on", 32'({oa, ob}), 32'(6'b010_010));
    repeat (4) @(negedge clk);
    check_eq("flash_on_last", 32'({oa, ob}), 32'(6'b010_010));
    @(negedge clk);
    check_eq("flash_off", 32'({oa, ob}), 32'd0);
    repeat (5) @(negedge clk);
    check_eq("flash_on_again", 32'({oa, ob}), 32'(6'b010_010));

    // asynchronous reset mid-flash
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("reset_mid_flash", 32'({oa, ob, flt, code}), 32'd0);
    la = 3'b000; lb = 3'b000; clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // long hold of one pattern
    drive(3'b001, 3'b100, 1'b0, 12 * T);
    check_eq("timeout_fault", 32'(flt), 32'(TO_EN));
    check_eq("timeout_code", 32'(code), TO_EN ? 32'd4 : 32'd0);
    drive(3'b000, 3'b000, 1'b1, 10);
    drive(3'b000, 3'b000, 1'b0, 3);

    // random traffic
    idx = 3;
    for (int seg = 0; seg < 300; seg++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (m_flt && $urandom_range(0, 2) == 0) begin
        drive(3'b000, 3'b000, 1'b1, $urandom_range(6, 12));
      end else if (kind <= 5) begin
        idx = (idx + 1) % 4;
        drive(norm[idx][5:3], norm[idx][2:0], 1'($urandom_range(0, 1)), $urandom_range(3, 25));
      end else if (kind == 6) begin
        drive(3'($urandom), 3'($urandom), 1'b0, 1);
        drive(norm[idx][5:3], norm[idx][2:0], 1'b0, 4);
      end else if (kind == 7) begin
        drive(3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 6));
      end else if (kind == 8) begin
        drive(3'b000, 3'b000, 1'($urandom_range(0, 1)), $urandom_range(3, 8));
      end else begin
        drive(norm[idx][5:3], norm[idx][2:0], 1'b0, $urandom_range(60, 110));
      end
    end

    @(negedge clk);
    cyc_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
